// File: rtl/tl45_register_read.sv
// Operand-fetch stage: register file, operand forwarding, execute input buffer.
// Latency: 1 cycle from decode fields to the registered o_* buffer.
// Backpressure: holds on execute stall, zeroes on flush, inserts a one-cycle bubble on load-use.
module tl45_register_read #(
  parameter logic [4:0] OP_LW = 5'h14
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [3:0]  i_sr1,
  input  logic [3:0]  i_sr2,
  input  logic [31:0] i_imm,
  input  logic        i_imm_sel,
  input  logic [3:0]  i_jmp_cond,
  input  logic [31:0] i_pc,
  input  logic [3:0]  i_of1_reg,
  input  logic [31:0] i_of1_val,
  input  logic [3:0]  i_of2_reg,
  input  logic [31:0] i_of2_val,
  input  logic [3:0]  i_wr_reg,
  input  logic [31:0] i_wr_val,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_dr,
  output logic [3:0]  o_jmp_cond,
  output logic [31:0] o_sr1_val,
  output logic [31:0] o_sr2_val,
  output logic [31:0] o_target_offset,
  output logic [31:0] o_pc
);

  // r0 is hardwired to zero, so only r1..r15 are storage.
  logic [31:0] rf_q [1:15];

  logic [4:0]  opcode_q, opcode_d;
  logic [3:0]  dr_q, dr_d;
  logic [3:0]  jmp_cond_q, jmp_cond_d;
  logic [31:0] sr1_val_q, sr1_val_d;
  logic [31:0] sr2_val_q, sr2_val_d;
  logic [31:0] target_offset_q, target_offset_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] rf_sr1, rf_sr2;
  logic [31:0] sr1_res, sr2_res;
  logic        hz;

  // Freshest-source priority: ALU forward, memory forward, writeback, register file.
  // A port naming r0 never matches because sr==0 is resolved first.
  function automatic logic [31:0] resolve(
    input logic [3:0]  sr,
    input logic [3:0]  of1_reg, input logic [31:0] of1_val,
    input logic [3:0]  of2_reg, input logic [31:0] of2_val,
    input logic [3:0]  wr_reg,  input logic [31:0] wr_val,
    input logic [31:0] rf_val
  );
    logic [31:0] v;
    if (sr == 4'd0)           v = 32'd0;
    else if (sr == of1_reg)   v = of1_val;
    else if (sr == of2_reg)   v = of2_val;
    else if (sr == wr_reg)    v = wr_val;
    else                      v = rf_val;
    return v;
  endfunction

  // Register file write port; writes to r0 are dropped by the != 0 test.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 1; i < 16; i++) rf_q[i] <= 32'd0;
    end else if (i_wr_reg != 4'd0) begin
      rf_q[i_wr_reg] <= i_wr_val;
    end
  end

  // Raw register file reads, re-evaluated every cycle so a held instruction sees new data.
  always_comb begin
    rf_sr1 = 32'd0;
    rf_sr2 = 32'd0;
    if (i_sr1 != 4'd0) rf_sr1 = rf_q[i_sr1];
    if (i_sr2 != 4'd0) rf_sr2 = rf_q[i_sr2];
  end

  // Operand resolution and load-use detection against the load currently in the buffer.
  always_comb begin
    sr1_res = resolve(i_sr1, i_of1_reg, i_of1_val, i_of2_reg, i_of2_val, i_wr_reg, i_wr_val, rf_sr1);
    sr2_res = resolve(i_sr2, i_of1_reg, i_of1_val, i_of2_reg, i_of2_val, i_wr_reg, i_wr_val, rf_sr2);
    hz = (opcode_q == OP_LW) && (dr_q != 4'd0) &&
         ((dr_q == i_sr1) || (!i_imm_sel && (dr_q == i_sr2)));
  end

  assign o_pipe_stall = i_pipe_stall || (hz && !i_pipe_flush);
  assign o_pipe_flush = i_pipe_flush;

  // Buffer next state: flush beats stall, stall beats the load-use bubble.
  always_comb begin
    opcode_d        = i_opcode;
    dr_d            = i_dr;
    jmp_cond_d      = i_jmp_cond;
    sr1_val_d       = sr1_res;
    sr2_val_d       = i_imm_sel ? i_imm : sr2_res;
    target_offset_d = i_imm;
    pc_d            = i_pc;
    if (i_pipe_flush || (!i_pipe_stall && hz)) begin
      opcode_d        = 5'd0;
      dr_d            = 4'd0;
      jmp_cond_d      = 4'd0;
      sr1_val_d       = 32'd0;
      sr2_val_d       = 32'd0;
      target_offset_d = 32'd0;
      pc_d            = 32'd0;
    end else if (i_pipe_stall) begin
      opcode_d        = opcode_q;
      dr_d            = dr_q;
      jmp_cond_d      = jmp_cond_q;
      sr1_val_d       = sr1_val_q;
      sr2_val_d       = sr2_val_q;
      target_offset_d = target_offset_q;
      pc_d            = pc_q;
    end
  end

  // Execute-stage input buffer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      opcode_q        <= 5'd0;
      dr_q            <= 4'd0;
      jmp_cond_q      <= 4'd0;
      sr1_val_q       <= 32'd0;
      sr2_val_q       <= 32'd0;
      target_offset_q <= 32'd0;
      pc_q            <= 32'd0;
    end else begin
      opcode_q        <= opcode_d;
      dr_q            <= dr_d;
      jmp_cond_q      <= jmp_cond_d;
      sr1_val_q       <= sr1_val_d;
      sr2_val_q       <= sr2_val_d;
      target_offset_q <= target_offset_d;
      pc_q            <= pc_d;
    end
  end

  assign o_opcode        = opcode_q;
  assign o_dr            = dr_q;
  assign o_jmp_cond      = jmp_cond_q;
  assign o_sr1_val       = sr1_val_q;
  assign o_sr2_val       = sr2_val_q;
  assign o_target_offset = target_offset_q;
  assign o_pc            = pc_q;

endmodule

// File: tb/tb_tl45_register_read.sv
// Directed bench for the TL45 operand-fetch stage with an expected-buffer scoreboard.
module tb_tl45_register_read;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_stall, i_pipe_flush;
  logic        o_pipe_stall, o_pipe_flush;
  logic [4:0]  i_opcode;
  logic [3:0]  i_dr, i_sr1, i_sr2, i_jmp_cond;
  logic [31:0] i_imm, i_pc;
  logic        i_imm_sel;
  logic [3:0]  i_of1_reg, i_of2_reg, i_wr_reg;
  logic [31:0] i_of1_val, i_of2_val, i_wr_val;
  logic [4:0]  o_opcode;
  logic [3:0]  o_dr, o_jmp_cond;
  logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  dr;
    logic [3:0]  jc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] off;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  tl45_register_read dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
    .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
    .i_imm(i_imm), .i_imm_sel(i_imm_sel), .i_jmp_cond(i_jmp_cond), .i_pc(i_pc),
    .i_of1_reg(i_of1_reg), .i_of1_val(i_of1_val),
    .i_of2_reg(i_of2_reg), .i_of2_val(i_of2_val),
    .i_wr_reg(i_wr_reg), .i_wr_val(i_wr_val),
    .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
    .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
    .o_target_offset(o_target_offset), .o_pc(o_pc)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [3:0] dr, input logic [3:0] jc,
                      input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] off, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.dr = dr; e.jc = jc; e.s1 = s1; e.s2 = s2; e.off = off; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Compares the buffer outputs against the oldest pending expectation.
  task automatic cmp_buf(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_op"},  {27'd0, o_opcode},   {27'd0, e.op});
      chk({tag, "_dr"},  {28'd0, o_dr},       {28'd0, e.dr});
      chk({tag, "_jc"},  {28'd0, o_jmp_cond}, {28'd0, e.jc});
      chk({tag, "_s1"},  o_sr1_val,           e.s1);
      chk({tag, "_s2"},  o_sr2_val,           e.s2);
      chk({tag, "_off"}, o_target_offset,     e.off);
      chk({tag, "_pc"},  o_pc,                e.pc);
    end
  endtask

  task automatic tick_cmp(input string tag);
    @(posedge i_clk);
    #1;
    cmp_buf(tag);
  endtask

  task automatic dec(input logic [4:0] op, input logic [3:0] dr, input logic [3:0] s1,
                     input logic [3:0] s2, input logic [31:0] imm, input logic sel,
                     input logic [3:0] jc, input logic [31:0] pc);
    @(negedge i_clk);
    i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2;
    i_imm = imm; i_imm_sel = sel; i_jmp_cond = jc; i_pc = pc;
  endtask

  initial begin
    i_reset = 1'b1;
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
    i_opcode = '0; i_dr = '0; i_sr1 = '0; i_sr2 = '0;
    i_imm = '0; i_imm_sel = 1'b0; i_jmp_cond = '0; i_pc = '0;
    i_of1_reg = '0; i_of1_val = '0; i_of2_reg = '0; i_of2_val = '0;
    i_wr_reg = '0; i_wr_val = '0;

    // Reset state.
    #12;
    push(0, 0, 0, 0, 0, 0, 0);
    cmp_buf("reset");
    chk("reset_stall", {31'd0, o_pipe_stall}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Writeback r3 then read it on both operands.
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    i_wr_reg = 4'd3; i_wr_val = 32'h1234;
    push(0, 0, 0, 0, 0, 0, 0);
    tick_cmp("wr_nop");
    dec(5'd1, 4'd1, 4'd3, 4'd3, 0, 0, 0, 32'h10);
    i_wr_reg = 4'd0; i_wr_val = 32'hDEAD;
    push(5'd1, 4'd1, 0, 32'h1234, 32'h1234, 0, 32'h10);
    tick_cmp("rf_read");

    // Forwarding priority: ALU > MEM > regfile.
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    i_wr_reg = 4'd3; i_wr_val = 32'h11;
    push(0, 0, 0, 0, 0, 0, 0);
    tick_cmp("wr_r3");
    dec(5'd1, 4'd2, 4'd3, 4'd5, 0, 0, 0, 32'h14);
    i_wr_reg = 4'd0;
    i_of1_reg = 4'd3; i_of1_val = 32'hAA;
    i_of2_reg = 4'd3; i_of2_val = 32'hBB;
    push(5'd1, 4'd2, 0, 32'hAA, 32'h0, 0, 32'h14);
    tick_cmp("fwd_alu");
    @(negedge i_clk);
    i_of1_reg = 4'd0;
    push(5'd1, 4'd2, 0, 32'hBB, 32'h0, 0, 32'h14);
    tick_cmp("fwd_mem");
    @(negedge i_clk);
    i_of2_reg = 4'd0;
    push(5'd1, 4'd2, 0, 32'h11, 32'h0, 0, 32'h14);
    tick_cmp("fwd_rf");

    // r0 always reads zero, even with forward ports at reg 0 and a write to r0.
    dec(5'd1, 4'd2, 4'd0, 4'd3, 0, 0, 0, 32'h18);
    i_of1_val = 32'hFF; i_wr_reg = 4'd0; i_wr_val = 32'h5;
    push(5'd1, 4'd2, 0, 32'h0, 32'h11, 0, 32'h18);
    tick_cmp("r0_fwd");
    dec(5'd1, 4'd2, 4'd0, 4'd0, 0, 0, 0, 32'h1C);
    i_wr_val = 32'h0;
    push(5'd1, 4'd2, 0, 32'h0, 32'h0, 0, 32'h1C);
    tick_cmp("r0_read");

    // Load-use interlock.
    dec(5'h14, 4'd4, 4'd0, 4'd0, 32'h8, 1'b1, 0, 32'h20);
    push(5'h14, 4'd4, 0, 32'h0, 32'h8, 32'h8, 32'h20);
    tick_cmp("lw");
    dec(5'd1, 4'd5, 4'd4, 4'd0, 0, 0, 0, 32'h24);
    #1;
    chk("hz_stall", {31'd0, o_pipe_stall}, 32'd1);
    push(0, 0, 0, 0, 0, 0, 0);
    tick_cmp("bubble");
    chk("hz_clear", {31'd0, o_pipe_stall}, 32'd0);
    @(negedge i_clk);
    i_of2_reg = 4'd4; i_of2_val = 32'h77;
    push(5'd1, 4'd5, 0, 32'h77, 32'h0, 0, 32'h24);
    tick_cmp("lw_fwd");

    // Execute stall holds the buffer for three edges while decode changes.
    dec(5'd2, 4'd6, 4'd7, 4'd8, 32'h99, 0, 4'd1, 32'h28);
    i_of2_reg = 4'd0;
    i_pipe_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(5'd1, 4'd5, 0, 32'h77, 32'h0, 0, 32'h24);
      tick_cmp("stall_hold");
      chk("stall_out", {31'd0, o_pipe_stall}, 32'd1);
    end

    // Flush together with stall: flush wins.
    @(negedge i_clk);
    i_pipe_flush = 1'b1;
    #1;
    chk("flush_pass", {31'd0, o_pipe_flush}, 32'd1);
    push(0, 0, 0, 0, 0, 0, 0);
    tick_cmp("flush");
    @(negedge i_clk);
    i_pipe_flush = 1'b0; i_pipe_stall = 1'b0;
    #1;
    chk("flush_rel", {31'd0, o_pipe_flush}, 32'd0);

    // Branch fields through the buffer.
    dec(5'h0C, 4'd0, 4'd0, 4'd9, 32'h40, 1'b1, 4'd4, 32'h100);
    push(5'h0C, 0, 4'd4, 32'h0, 32'h40, 32'h40, 32'h100);
    tick_cmp("branch");

    // Asynchronous reset between edges, then first edge after release latches decode.
    #2;
    i_reset = 1'b1;
    #1;
    push(0, 0, 0, 0, 0, 0, 0);
    cmp_buf("async_rst");
    @(negedge i_clk);
    i_reset = 1'b0;
    push(5'h0C, 0, 4'd4, 32'h0, 32'h40, 32'h40, 32'h100);
    tick_cmp("post_rst");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
